// File: rtl/rx_rate_sampler.sv
// rx_rate_sampler: windowed rate sampler for a free-running RX packet counter.
// Each window of `interval` clocks produces one {seq, delta} sample, which is
// queued in a small FIFO and drained AXI-Stream style.
// Optional feature: define RX_RATE_PEAK_EN to track the largest delta seen
// since reset on peak_rate; otherwise peak_rate is tied to zero.
module rx_rate_sampler #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rx_count,
  input  logic        enable,
  input  logic [31:0] interval,
  output logic [63:0] sample_tdata,
  output logic        sample_tvalid,
  input  logic        sample_tready,
  output logic [6:0]  fifo_level,
  output logic [15:0] overflow_count,
  output logic [31:0] peak_rate
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0] DEPTH_L = 7'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_tick;
  logic [31:0]     r_baseline;
  logic [31:0]     r_seq;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [6:0]      r_level;
  logic [15:0]     r_ovf;
  logic [63:0]     r_mem [FIFO_DEPTH];

  logic            w_start;
  logic            w_win_active;
  logic            w_close;
  logic [31:0]     w_delta;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  // Window bookkeeping: a window only advances while running with a nonzero
  // interval; modular subtraction makes counter wrap come out right.
  assign w_start      = (r_state == S_IDLE) && enable;
  assign w_win_active = (r_state == S_RUN) && enable && (interval != 32'd0);
  assign w_close      = w_win_active && (r_tick >= (interval - 32'd1));
  assign w_delta      = rx_count - r_baseline;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_full = (r_level == DEPTH_L);
  assign w_pop  = sample_tvalid && sample_tready;
  assign w_push = w_close && (!w_full || w_pop);
  assign w_drop = w_close && w_full && !w_pop;

  assign sample_tvalid  = (r_level != 7'd0);
  assign sample_tdata   = sample_tvalid ? r_mem[r_rd_ptr] : 64'd0;
  assign fifo_level     = r_level;
  assign overflow_count = r_ovf;

  // Run/stop state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: enable alone decides run versus idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable)  w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tick counter and baseline: restart on entry to RUN and on every close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick     <= 32'd0;
      r_baseline <= 32'd0;
    end else if (w_start || w_close) begin
      r_tick     <= 32'd0;
      r_baseline <= rx_count;
    end else if (w_win_active) begin
      r_tick     <= r_tick + 32'd1;
    end
  end

  // Sequence number advances on every close, including dropped samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_seq <= 32'd0;
    else if (w_close) r_seq <= r_seq + 32'd1;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 7'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 7'd1;
        2'b01:   r_level <= r_level - 7'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sample storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_seq, w_delta};
  end

  // Saturating count of samples lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_ovf <= 16'd0;
    else if (w_drop && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
  end

`ifdef RX_RATE_PEAK_EN
  logic [31:0] r_peak;

  // Peak tracker sees every closed window, whether or not it was queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_peak <= 32'd0;
    else if (w_close && (w_delta > r_peak))    r_peak <= w_delta;
  end

  assign peak_rate = r_peak;
`else
  assign peak_rate = 32'd0;
`endif

endmodule
